// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//   I2S bus master for the anti-noise output path. Divides the system clock
//   down to BCLK and generates LRCLK over a fixed 64-BCLK frame (32-bit slot
//   per channel). Samples are shifted out MSB first, with the standard I2S
//   one-bit delay. A one-entry holding register decouples the producer from
//   the frame timing.
// Ports
//   clk_in, rst_in        system clock, synchronous active-high reset
//   ready_in              1-cycle strobe, left_in/right_in valid
//   left_in, right_in     signed channel samples (SAMPLE_WIDTH bits)
//   i2s_bclk_out          bit clock
//   i2s_lrclk_out         word select (0 = left, 1 = right)
//   i2s_data_out          serial data, updated on BCLK falling edge
//   sample_taken_out      pulse: new sample loaded into the active registers
//   underrun_out          pulse: frame started with no new sample (repeat)
//   overrun_out           pulse: ready_in overwrote an unsent held sample
module i2s_transmitter #(
  parameter int BCLK_HALF    = 12,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    ready_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    sample_taken_out,
  output logic                    underrun_out,
  output logic                    overrun_out
);
  localparam int SW    = SAMPLE_WIDTH;
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             data_q, data_d;
  logic [SW-1:0]    hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic             hold_v_q, hold_v_d;
  logic [SW-1:0]    act_l_q, act_l_d, act_r_q, act_r_d;
  logic             taken_q, taken_d, under_q, under_d, over_q, over_d;

  logic       term, fall, wrap;
  logic [5:0] cnt_nxt;
  logic [31:0] slot;

  always_comb begin
    term    = (div_q == DIV_W'(BCLK_HALF - 1));
    fall    = term & bclk_q;
    wrap    = fall & (bit_cnt_q == 6'd63);
    cnt_nxt = bit_cnt_q + 6'd1;
    // Slot image: bit 31 is the one-bit delay, word MSB at bit 30, zero pad below.
    slot    = (cnt_nxt[5] ? 32'(act_r_q) : 32'(act_l_q)) << (31 - SW);

    div_d     = term ? '0 : div_q + 1'b1;
    bclk_d    = term ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    data_d    = data_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    hold_v_d  = hold_v_q;
    act_l_d   = act_l_q;
    act_r_d   = act_r_q;
    taken_d   = 1'b0;
    under_d   = 1'b0;
    over_d    = 1'b0;

    if (fall) begin
      bit_cnt_d = cnt_nxt;
      lrclk_d   = cnt_nxt[5];
      // On the wrap the new position is p=0, which is always 0, so using the
      // pre-load active registers here is safe.
      data_d    = slot[5'd31 - cnt_nxt[4:0]];
    end

    if (wrap) begin
      if (hold_v_q) begin
        act_l_d  = hold_l_q;
        act_r_d  = hold_r_q;
        taken_d  = 1'b1;
        // A coincident strobe refills the slot the load just vacated.
        if (ready_in) begin
          hold_l_d = left_in;
          hold_r_d = right_in;
        end else begin
          hold_v_d = 1'b0;
        end
      end else if (ready_in) begin
        act_l_d = left_in;
        act_r_d = right_in;
        taken_d = 1'b1;
      end else begin
        under_d = 1'b1;
      end
    end else if (ready_in) begin
      hold_l_d = left_in;
      hold_r_d = right_in;
      hold_v_d = 1'b1;
      over_d   = hold_v_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrclk_q   <= 1'b0;
      data_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      hold_v_q  <= 1'b0;
      act_l_q   <= '0;
      act_r_q   <= '0;
      taken_q   <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      data_q    <= data_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      hold_v_q  <= hold_v_d;
      act_l_q   <= act_l_d;
      act_r_q   <= act_r_d;
      taken_q   <= taken_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  assign i2s_bclk_out     = bclk_q;
  assign i2s_lrclk_out    = lrclk_q;
  assign i2s_data_out     = data_q;
  assign sample_taken_out = taken_q;
  assign underrun_out     = under_q;
  assign overrun_out      = over_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// tb_i2s_transmitter
//   Frame-level scoreboard for i2s_transmitter: a sample-level model pushes
//   the expected 64-bit frame at each frame boundary; a serial monitor
//   rebuilds frames from the bus and pops/compares them.
module tb_i2s_transmitter;
  localparam int BH = 12;
  localparam int FR = 128 * BH;

  logic clk = 1'b0, rst = 1'b1, ready = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic bclk, lrclk, data, taken, under, over;

  i2s_transmitter #(.BCLK_HALF(BH), .SAMPLE_WIDTH(16)) dut (
    .clk_in(clk), .rst_in(rst), .ready_in(ready), .left_in(left), .right_in(right),
    .i2s_bclk_out(bclk), .i2s_lrclk_out(lrclk), .i2s_data_out(data),
    .sample_taken_out(taken), .underrun_out(under), .overrun_out(over)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] build(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] f;
    logic [15:0] w;
    int p;
    f = '0;
    for (int c = 0; c < 64; c++) begin
      p = c % 32;
      w = (c < 32) ? l : r;
      if (p >= 1 && p <= 16) f[c] = w[4'(16 - p)];
    end
    return f;
  endfunction

  // ---------------- model: expected frame per boundary ----------------
  logic [63:0] exp_q[$];
  int cyc = 0;
  logic [15:0] m_hl, m_hr, m_al, m_ar;
  logic m_hv;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc = 0; m_hv = 0; m_al = '0; m_ar = '0; m_hl = '0; m_hr = '0;
        exp_q.delete();
        exp_q.push_back(64'd0);
      end else begin
        cyc++;
        if (cyc % FR == 0) begin
          if (m_hv) begin
            m_al = m_hl; m_ar = m_hr;
            if (ready) begin m_hl = left; m_hr = right; end
            else m_hv = 0;
          end else if (ready) begin
            m_al = left; m_ar = right;
          end
          exp_q.push_back(build(m_al, m_ar));
        end else if (ready) begin
          m_hl = left; m_hr = right; m_hv = 1;
        end
      end
    end
  end

  // ---------------- monitor: rebuild frames from the bus ----------------
  logic [5:0] mon_cnt;
  logic [63:0] frame_bits, last_frame;
  int mcyc, last_edge, falls, lr_rise_at;
  bit first_edge, prev_bclk, prev_lr, prev_data;
  int obs_taken = 0, obs_under = 0, obs_over = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_cnt = '0; frame_bits = '0; mcyc = 0; falls = 0; lr_rise_at = -1;
        first_edge = 1; prev_bclk = 0; prev_lr = 0; prev_data = 0;
      end else begin
        bit fell;
        mcyc++;
        fell = prev_bclk && !bclk;
        if (bclk != prev_bclk) begin
          if (!first_edge) check("bclk_half", 64'(mcyc - last_edge), 64'(BH));
          first_edge = 0;
          last_edge = mcyc;
        end
        if (data != prev_data) check("data_on_fall", 64'(fell), 64'd1);
        if (fell) begin
          falls++;
          mon_cnt = mon_cnt + 6'd1;
          check("lrclk", 64'(lrclk), 64'(mon_cnt[5]));
          if (lrclk && !prev_lr && lr_rise_at < 0) lr_rise_at = falls;
          prev_lr = lrclk;
          if (mon_cnt == 6'd0) begin
            check("frame_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("frame", frame_bits, exp_q.pop_front());
            last_frame = frame_bits;
            frame_bits = '0;
          end
          frame_bits[mon_cnt] = data;
        end
        prev_bclk = bclk;
        prev_data = data;
        if (taken) obs_taken++;
        if (under) obs_under++;
        if (over)  obs_over++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int t);
    int g = 0;
    while (cyc < t && g < 60000) begin @(negedge clk); g++; end
    check("wait_cyc", 64'(cyc), 64'(t));
  endtask

  task automatic drive(input logic [15:0] l, input logic [15:0] r);
    left = l; right = r; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pulse_counts(input string tag, input int t, input int u, input int o);
    check({tag, "_taken"}, 64'(obs_taken), 64'(t));
    check({tag, "_under"}, 64'(obs_under), 64'(u));
    check({tag, "_over"},  64'(obs_over),  64'(o));
  endtask

  initial begin
    logic [15:0] w;
    int g;
    // reset state
    repeat (3) @(negedge clk);
    #1 check("rst_outs", {58'd0, bclk, lrclk, data, taken, under, over}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle frames -> zero data, one underrun per frame
    wait_cyc(3 * FR + 100);
    pulse_counts("t1", 0, 3, 0);

    // 2: one sample mid-frame, carried by frame 4
    wait_cyc(3 * FR + 500);
    drive(16'hA5C3, 16'h8001);
    wait_cyc(5 * FR + 100);
    for (int i = 0; i < 16; i++) w[15 - i] = last_frame[1 + i];
    check("t2_left", 64'(w), 64'hA5C3);
    for (int i = 0; i < 16; i++) w[15 - i] = last_frame[33 + i];
    check("t2_right", 64'(w), 64'h8001);
    check("t2_pad", {34'd0, last_frame[31:17], last_frame[0], last_frame[63:49], last_frame[32]}, 64'd0);
    pulse_counts("t2", 1, 4, 0);

    // 3: two strobes in one frame -> overrun, second wins
    wait_cyc(5 * FR + 300);
    drive(16'h0001, 16'h1111);
    wait_cyc(5 * FR + 800);
    drive(16'h0002, 16'h2222);
    wait_cyc(6 * FR + 100);
    pulse_counts("t3", 2, 4, 1);

    // 4a: strobe on the wrap cycle with hold empty -> bypass
    wait_cyc(7 * FR - 1);
    drive(16'h7FFF, 16'hC001);
    wait_cyc(7 * FR + 100);
    pulse_counts("t4a", 3, 4, 1);
    // 4b: hold full, strobe on wrap -> old sent, new held
    wait_cyc(7 * FR + 400);
    drive(16'h1234, 16'h5678);
    wait_cyc(8 * FR - 1);
    drive(16'h4321, 16'h8765);
    wait_cyc(9 * FR + 100);
    pulse_counts("t4b", 5, 4, 1);

    // 5: no new data -> repeat and underrun
    wait_cyc(11 * FR + 100);
    pulse_counts("t5", 5, 6, 1);

    // 6: fill hold, then reset at bit_cnt 40
    wait_cyc(11 * FR + 200);
    drive(16'hBEEF, 16'hCAFE);
    g = 0;
    while (falls != 11 * 64 + 40 && g < 4000) begin @(negedge clk); #1; g++; end
    check("t6_bit40", 64'(falls), 64'(11 * 64 + 40));
    rst = 1'b1;
    @(negedge clk);
    #1 check("t6_rst_outs", {58'd0, bclk, lrclk, data, taken, under, over}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(2 * FR + 100);
    check("t6_lr_rise", 64'(lr_rise_at), 64'd32);
    pulse_counts("t6", 5, 8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
